// File: rtl/matrix_pkg.sv
// Shared constants, types and helpers for the matrix packer front end.
package matrix_pkg;

    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int OUT_W   = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int CNT_W   = 5;

    typedef logic [2:0] dim_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic dim_legal(input dim_t n);
        return (n != 3'd0) && (n <= dim_t'(MAX_DIM));
    endfunction

    function automatic logic [CNT_W-1:0] dim_sq(input dim_t n);
        return CNT_W'(int'(n) * int'(n));
    endfunction

    // Element k lands just below element k-1, first element at the top of the used region.
    function automatic logic [7:0] elem_msb(input dim_t n, input logic [CNT_W-1:0] k);
        int msb;
        msb = int'(n) * int'(n) * ELEM_W - 1 - int'(k) * ELEM_W;
        return 8'(msb);
    endfunction

endpackage

// File: rtl/matrix_packer_if.sv
// Element input and packed-matrix output bundle of the matrix packer.
interface matrix_packer_if;
    import matrix_pkg::*;

    // Both ports transfer on a rising edge where valid and ready are high;
    // valid never waits on ready and the payload is held while valid is high.
    dim_t               size;
    logic               in_valid;
    logic [ELEM_W-1:0]  in_data;
    logic               in_ready;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    dim_t               out_size;
    logic               size_err;

    modport master (
        output size, in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_size, size_err
    );

    modport slave (
        input  size, in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_size, size_err
    );

endinterface

// File: rtl/matrix_packer.sv
// Packs row-major signed elements into one matrix word; MATRIX_PACKER_COUNT_EN adds a transfer counter.
module matrix_packer
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    matrix_packer_if.slave  bus,
`ifdef MATRIX_PACKER_COUNT_EN
    output logic [15:0]     mat_count,
`endif
    output state_t          dbg_state_o
);

    state_t             state_q;
    dim_t               n_q;
    dim_t               out_size_q;
    logic [CNT_W-1:0]   count_q;
    logic [OUT_W-1:0]   pack_q;
    logic [OUT_W-1:0]   pack_d;
    logic               out_valid_q;
    logic               size_err_q;
    logic               in_ready_d;
    dim_t               wr_dim;
    logic [CNT_W-1:0]   wr_k;
    logic [7:0]         wr_msb;

    assign in_ready_d = !rst && !bus.flush && (state_q != HOLD);

    // A new matrix starts from a cleared word so unused high bits read as zero.
    always_comb begin
        wr_dim = (state_q == IDLE) ? bus.size : n_q;
        wr_k   = (state_q == IDLE) ? '0 : count_q;
        wr_msb = elem_msb(dim_legal(wr_dim) ? wr_dim : dim_t'(1), wr_k);
        pack_d = (state_q == IDLE) ? '0 : pack_q;
        pack_d[wr_msb -: ELEM_W] = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            out_size_q  <= '0;
            count_q     <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            size_err_q <= 1'b0;
            if (bus.flush) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                count_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.in_valid) begin
                            if (dim_legal(bus.size)) begin
                                n_q        <= bus.size;
                                out_size_q <= bus.size;
                                pack_q     <= pack_d;
                                count_q    <= CNT_W'(1);
                                if (bus.size == 3'd1) begin
                                    state_q     <= HOLD;
                                    out_valid_q <= 1'b1;
                                end else begin
                                    state_q <= FILL;
                                end
                            end else begin
                                size_err_q <= 1'b1;
                            end
                        end
                    end
                    FILL: begin
                        if (bus.in_valid) begin
                            pack_q  <= pack_d;
                            count_q <= count_q + CNT_W'(1);
                            if (count_q + CNT_W'(1) == dim_sq(n_q)) begin
                                state_q     <= HOLD;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (bus.out_ready) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            count_q     <= '0;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        count_q     <= '0;
                    end
                endcase
            end
        end
    end

`ifdef MATRIX_PACKER_COUNT_EN
    logic [15:0] mat_count_q;

    // Only real handshakes count; a flush in HOLD drops the matrix uncounted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_count_q <= '0;
        end else if ((state_q == HOLD) && bus.out_ready && !bus.flush) begin
            mat_count_q <= mat_count_q + 16'd1;
        end
    end

    assign mat_count = mat_count_q;
`endif

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = pack_q;
    assign bus.out_size  = out_size_q;
    assign bus.size_err  = size_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_matrix_packer.sv
// Directed and randomized checks of matrix_packer against a shift-accumulate packing model.
module tb_matrix_packer;
    import matrix_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     errors;
    int     checks;

    logic [OUT_W-1:0] exp_q[$];
    dim_t             exp_size_q[$];

`ifdef MATRIX_PACKER_COUNT_EN
    logic [15:0] mat_count;
`endif

    matrix_packer_if bus();

    matrix_packer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
`ifdef MATRIX_PACKER_COUNT_EN
        .mat_count   (mat_count),
`endif
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chkw(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: shifting each element in from the right leaves element 0 in the top byte.
    function automatic logic [OUT_W-1:0] model_pack(input logic [7:0] e[$]);
        logic [OUT_W-1:0] w;
        w = '0;
        foreach (e[i]) w = (w << ELEM_W) | OUT_W'(e[i]);
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] d, input dim_t s);
        int waitc;
        waitc = 0;
        bus.size     = s;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
            #1;
        end
        chk1("in_ready_wait", waitc < 20, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_matrix(input int n, input logic [7:0] e[$], input dim_t later_size);
        for (int k = 0; k < n * n; k++) begin
            push(e[k], (k == 0) ? dim_t'(n) : later_size);
            if (k < n * n - 1) chk1("early_valid", bus.out_valid, 1'b0);
        end
        chk1("latency_valid", bus.out_valid, 1'b1);
        exp_q.push_back(model_pack(e));
        exp_size_q.push_back(dim_t'(n));
    endtask

    task automatic take(input int hold);
        logic [OUT_W-1:0] e;
        dim_t             es;
        e  = exp_q.pop_front();
        es = exp_size_q.pop_front();
        chk1("out_valid", bus.out_valid, 1'b1);
        chkw("out_data", bus.out_data, e);
        chkw("out_size", OUT_W'(bus.out_size), OUT_W'(es));
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk1("hold_valid", bus.out_valid, 1'b1);
            chkw("hold_data", bus.out_data, e);
            chk1("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk1("post_xfer_valid", bus.out_valid, 1'b0);
        chkw("post_xfer_data", bus.out_data, e);
        chkw("post_xfer_state", OUT_W'(dbg_state), OUT_W'(IDLE));
    endtask

    task automatic random_matrix(input int hold);
        logic [7:0] e[$];
        int         n;
        n = $urandom_range(1, MAX_DIM);
        e = {};
        for (int k = 0; k < n * n; k++) e.push_back(8'($urandom_range(0, 255)));
        send_matrix(n, e, dim_t'(n));
        take(hold);
    endtask

    initial begin
        logic [7:0] e[$];
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.size = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        chk1("reset_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chkw("reset_out_data", bus.out_data, '0);
        chkw("reset_out_size", OUT_W'(bus.out_size), '0);
        chk1("reset_size_err", bus.size_err, 1'b0);
        chkw("reset_state", OUT_W'(dbg_state), OUT_W'(IDLE));

        // 2x2 with immediate consumer
        e = '{8'd3, 8'hFE, 8'd5, 8'd7};
        send_matrix(2, e, dim_t'(2));
        chkw("word_2x2", bus.out_data, OUT_W'(32'h03FE0507));
        take(0);

        // 3x3 with backpressure
        e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_matrix(3, e, dim_t'(3));
        chkw("word_3x3", bus.out_data, OUT_W'(72'h010203040506070809));
        take(5);

        // size changes after the first element are ignored
        e = '{8'h80, 8'h7F, 8'h00, 8'hFF};
        send_matrix(2, e, dim_t'(4));
        take(1);

        // illegal sizes
        push(8'h11, dim_t'(0));
        chk1("size_err_0", bus.size_err, 1'b1);
        chkw("size_err_0_state", OUT_W'(dbg_state), OUT_W'(IDLE));
        chk1("size_err_0_valid", bus.out_valid, 1'b0);
        push(8'h22, dim_t'(6));
        chk1("size_err_6", bus.size_err, 1'b1);
        chkw("size_err_6_state", OUT_W'(dbg_state), OUT_W'(IDLE));
        @(negedge clk);
        chk1("size_err_pulse_end", bus.size_err, 1'b0);
        chk1("size_err_no_valid", bus.out_valid, 1'b0);

        // flush in FILL with a competing element
        push(8'hAA, dim_t'(2));
        push(8'hBB, dim_t'(2));
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hCC;
        #1;
        chk1("flush_blocks_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chkw("flush_fill_state", OUT_W'(dbg_state), OUT_W'(IDLE));
        chk1("flush_fill_valid", bus.out_valid, 1'b0);

        // flush in HOLD beats out_ready
        for (int k = 0; k < 4; k++) push(8'(k + 16), dim_t'(2));
        chk1("hold_before_flush", bus.out_valid, 1'b1);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        chk1("flush_hold_valid", bus.out_valid, 1'b0);
        chkw("flush_hold_state", OUT_W'(dbg_state), OUT_W'(IDLE));
        e = '{8'd1, 8'd2, 8'd3, 8'd4};
        send_matrix(2, e, dim_t'(2));
        chkw("word_after_flush", bus.out_data, OUT_W'(32'h01020304));
        take(0);

        // randomized matrices
        for (int m = 0; m < 8; m++) random_matrix($urandom_range(0, 3));

        // synchronous reset mid-FILL
        push(8'h5A, dim_t'(3));
        push(8'hA5, dim_t'(3));
        rst = 1'b1;
        #1;
        chk1("rst_mid_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk1("rst_mid_valid", bus.out_valid, 1'b0);
        chkw("rst_mid_data", bus.out_data, '0);
        chkw("rst_mid_size", OUT_W'(bus.out_size), '0);
        chk1("rst_mid_size_err", bus.size_err, 1'b0);
        chkw("rst_mid_state", OUT_W'(dbg_state), OUT_W'(IDLE));
`ifdef MATRIX_PACKER_COUNT_EN
        chkw("rst_mat_count", OUT_W'(mat_count), '0);
`endif
        for (int m = 0; m < 3; m++) random_matrix($urandom_range(0, 2));
`ifdef MATRIX_PACKER_COUNT_EN
        chkw("mat_count_3", OUT_W'(mat_count), OUT_W'(3));
`endif
        chk1("queue_drained", exp_q.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_packer.md
Name: matrix_packer

Overview:
- Sequential front end for the arithmetic operation blocks.
- Accepts signed 8-bit matrix elements one per handshake, in row-major order, and packs them into the compact matrix word that the operation units consume.
- For 2x2 the word layout is a11 at [31:24], a12 at [23:16], a21 at [15:8] and a22 at [7:0].
- Presents the finished word on a valid/ready output port.

Parameters:
- ELEM_W, 8, width of one signed matrix element.
- MAX_DIM, 5, largest supported matrix dimension.
- OUT_W, MAX_DIM*MAX_DIM*ELEM_W, packed output width (200 at default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- size  in  3  matrix dimension n (1..MAX_DIM); sampled only on the first element of a matrix.
- in_valid  in  1  element present.
- in_data  in  ELEM_W  signed element, row-major order.
- in_ready  out  1  element accepted on a cycle where in_valid and in_ready are both high.
- flush  in  1  abort the current matrix.
- out_valid  out  1  packed matrix available.
- out_ready  in  1  consumer accepts the matrix.
- out_data  out  OUT_W  packed matrix.
- out_size  out  3  dimension of out_data.
- size_err  out  1  one-cycle pulse when an element is dropped because size was illegal.

Behaviour:
- Reset values: in_ready=0 during reset; out_valid=0, out_data=0, out_size=0, size_err=0, state=IDLE, element count=0.
- FSM states: IDLE, FILL, HOLD.
- in_ready is high in IDLE and FILL, low in HOLD, and low in any cycle where flush=1.
- IDLE, element accepted with legal size (1..MAX_DIM):
  - Latch n; clear the pack register; write the element; count=1.
  - If n==1, go to HOLD; otherwise go to FILL.
- IDLE, element accepted with size 0 or >MAX_DIM:
  - Discard the element, pulse size_err on the next cycle, stay in IDLE.
- FILL: each accepted element k (0-based) is written to bits [n*n*ELEM_W-1-k*ELEM_W -: ELEM_W].
  - Changes on size are ignored until the next IDLE.
  - When count reaches n*n, go to HOLD.
- Packed layout:
  - The used region is the low n*n*ELEM_W bits, first element in the most significant byte.
  - Bits above the used region are 0.
  - Values are stored verbatim, with no sign extension.
- Latency: last element accepted at edge t gives out_valid=1 after edge t (visible in cycle t+1).
- HOLD:
  - out_valid=1; out_data and out_size are stable until the transfer.
  - When out_valid and out_ready are both high at an edge, go to IDLE; out_valid=0 in the next cycle and out_data keeps its value.
  - There is no back-to-back acceptance: at least one bubble cycle between matrices.
- flush:
  - Takes priority over any element in the same cycle.
  - From FILL, discards partial data and goes to IDLE.
  - From HOLD, drops the pending matrix with out_valid=0 next cycle, even if out_ready=1 in the same cycle.
- Synchronous reset mid-operation has the same effect as flush and also clears out_data.

Optional Feature:
- Macro: MATRIX_PACKER_COUNT_EN.
- Defined:
  - Adds output port mat_count (16 bits, reset 0).
  - Increments on each completed out_valid/out_ready transfer and wraps from 0xFFFF to 0.
  - Flushed or dropped matrices are not counted.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package matrix_pkg holds:
  - ELEM_W and MAX_DIM constants.
  - The 3-bit dimension type.
  - The packer FSM state enum {IDLE, FILL, HOLD}.
  - A function giving the MSB index of element k for dimension n.
- No sub-module: the FSM, counter and pack register are a single flat block.

Test Plan:
- 2x2 matrix:
  - Stimulus: size=2; elements 3, -2, 5, 7; out_ready=1.
  - Required: out_data[31:0]=0x03FE0507, upper bits 0, out_size=2, out_valid asserted exactly one cycle after the 4th acceptance.
- 3x3 matrix with backpressure:
  - Stimulus: size=3; elements 1..9; out_ready held 0 for 5 cycles.
  - Required: out_data[71:0]=0x010203040506070809 held stable, in_ready=0 throughout HOLD, a single transfer when out_ready rises.
- Mid-matrix size change:
  - Stimulus: size=2 for element 0, then size switched to 4 for elements 1..3.
  - Required: matrix completes after 4 elements with out_size=2.
- Illegal size:
  - Stimulus: size=0 with element 0x11, then size=6 with element 0x22.
  - Required: two size_err pulses, state remains IDLE, no out_valid.
- Flush in FILL and HOLD:
  - Stimulus: flush after 2 of 4 elements; later, flush in HOLD with out_ready=1 in the same cycle.
  - Required: no matrix emitted in either case; the next 2x2 of 1, 2, 3, 4 gives 0x01020304.
- Reset mid-FILL, with MATRIX_PACKER_COUNT_EN defined:
  - Stimulus: assert rst=1 for 1 cycle during FILL.
  - Required: all outputs return to reset values; after 3 completed matrices mat_count=3.
